// File: rtl/data_out_buffer.sv
// data_out_buffer: write-back FIFO between the CPU and memory.
// Holds up to DEPTH {addr,data} pairs. Memory sees the head entry through a
// valid/ready handshake, and the CPU pushes through its own valid/ready pair.
// Widths come from `WORD_SIZE (defines.vh); a 16-bit fallback is used when
// the macro has not been defined before this file is compiled.
// Optional feature: define DATA_OUT_BUFFER_BYPASS_EN to let a request reach
// memory in the same cycle when the buffer is empty.

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module data_out_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      areset_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [`WORD_SIZE-1:0]     wr_addr,
    input  logic [`WORD_SIZE-1:0]     wr_data,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [`WORD_SIZE-1:0]     mem_addr,
    output logic [`WORD_SIZE-1:0]     mem_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      idle
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned W  = `WORD_SIZE;

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [W-1:0]  addr_mem [DEPTH];
    logic [W-1:0]  data_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;

    logic empty;
    logic full;
    logic bypass_hit;
    logic bypass_take;
    logic do_push;
    logic do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

`ifdef DATA_OUT_BUFFER_BYPASS_EN
    assign bypass_hit = empty && wr_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    // A bypassed request that memory takes immediately is never stored.
    assign bypass_take = bypass_hit && mem_ready;
    assign do_push     = wr_valid && wr_ready && !bypass_take;
    assign do_pop      = !empty && mem_ready;

    assign wr_ready = !full;
    assign count    = count_q;
    assign idle     = empty && !bypass_hit;

    // Present the head entry (or the bypassed request) to memory; zeros when idle.
    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        if (!empty) begin
            mem_valid = 1'b1;
            mem_addr  = addr_mem[rd_ptr];
            mem_data  = data_mem[rd_ptr];
        end else if (bypass_hit) begin
            mem_valid = 1'b1;
            mem_addr  = wr_addr;
            mem_data  = wr_data;
        end
    end

    // Entry storage; cleared on reset so nothing stale can surface afterwards.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (do_push) begin
            addr_mem[wr_ptr] <= wr_addr;
            data_mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Occupancy: unchanged when push and pop coincide.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            count_q <= '0;
        end else if (do_push && !do_pop) begin
            count_q <= count_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            count_q <= count_q - CNT_ONE;
        end
    end

endmodule

// File: tb/tb_data_out_buffer.sv
// tb_data_out_buffer: table-driven vectors, directed corner sequences and a
// randomized run checked against a queue-based reference model.

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_data_out_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = `WORD_SIZE;
`ifdef DATA_OUT_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk;
    logic                   areset_n;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [W-1:0]           wr_addr;
    logic [W-1:0]           wr_data;
    logic                   mem_valid;
    logic                   mem_ready;
    logic [W-1:0]           mem_addr;
    logic [W-1:0]           mem_data;
    logic [$clog2(DEPTH):0] count;
    logic                   idle;

    data_out_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .count     (count),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: an ordered list of pending {addr,data} writes.
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] d;
    } ent_t;
    ent_t q[$];

    // One clock: drive inputs, compare outputs to the model mid-cycle, advance.
    task automatic cycle(input logic wv, input logic [W-1:0] a, input logic [W-1:0] d,
                         input logic mr, output logic acc);
        logic         byp, e_mv, e_wr, e_idle;
        logic [W-1:0] e_ma, e_md;
        wr_valid  = wv;
        wr_addr   = a;
        wr_data   = d;
        mem_ready = mr;
        byp    = BYP && wv && (q.size() == 0);
        e_wr   = (q.size() < DEPTH);
        e_mv   = 1'b0;
        e_ma   = '0;
        e_md   = '0;
        if (q.size() > 0) begin
            e_mv = 1'b1; e_ma = q[0].a; e_md = q[0].d;
        end else if (byp) begin
            e_mv = 1'b1; e_ma = a; e_md = d;
        end
        e_idle = (q.size() == 0) && !byp;
        #2;
        check("mem_valid", 32'(mem_valid), 32'(e_mv));
        check("wr_ready",  32'(wr_ready),  32'(e_wr));
        check("mem_addr",  32'(mem_addr),  32'(e_ma));
        check("mem_data",  32'(mem_data),  32'(e_md));
        check("count",     32'(count),     32'(q.size()));
        check("idle",      32'(idle),      32'(e_idle));
        acc = wv && e_wr;
        if (!(byp && mr)) begin
            if (e_mv && mr) void'(q.pop_front());
            if (acc) q.push_back('{a: a, d: d});
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         wv;
        logic [W-1:0] a;
        logic [W-1:0] d;
        logic         mr;
        logic         e_mv;
        logic         e_wr;
        logic [W-1:0] e_ma;
        logic [W-1:0] e_md;
        int unsigned  e_cnt;
    } vec_t;

    function automatic vec_t mk(logic wv, logic [W-1:0] a, logic [W-1:0] d, logic mr,
                                logic e_mv, logic e_wr, logic [W-1:0] e_ma,
                                logic [W-1:0] e_md, int unsigned e_cnt);
        vec_t v;
        v.wv = wv; v.a = a; v.d = d; v.mr = mr;
        v.e_mv = e_mv; v.e_wr = e_wr; v.e_ma = e_ma; v.e_md = e_md; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        vec_t         vecs[15];
        logic         acc;
        logic         pending;
        logic [W-1:0] ra, rd;
        logic         mr;
        logic         popped;

        // Rows: inputs this cycle, then outputs expected before the edge.
        vecs[0]  = mk(1, 'h0010, 'h0005, 1, 0, 1, 'h0000, 'h0000, 0);
        vecs[1]  = mk(0, 'h0000, 'h0000, 1, 1, 1, 'h0010, 'h0005, 1);
        vecs[2]  = mk(0, 'h0000, 'h0000, 0, 0, 1, 'h0000, 'h0000, 0);
        vecs[3]  = mk(1, 'h0101, 'h0001, 0, 0, 1, 'h0000, 'h0000, 0);
        vecs[4]  = mk(1, 'h0102, 'h0002, 0, 1, 1, 'h0101, 'h0001, 1);
        vecs[5]  = mk(1, 'h0103, 'h0003, 0, 1, 1, 'h0101, 'h0001, 2);
        vecs[6]  = mk(1, 'h0104, 'h0004, 0, 1, 1, 'h0101, 'h0001, 3);
        vecs[7]  = mk(1, 'h0105, 'h0005, 0, 1, 0, 'h0101, 'h0001, 4);
        vecs[8]  = mk(1, 'h0105, 'h0005, 1, 1, 0, 'h0101, 'h0001, 4);
        vecs[9]  = mk(1, 'h0105, 'h0005, 0, 1, 1, 'h0102, 'h0002, 3);
        vecs[10] = mk(0, 'h0000, 'h0000, 1, 1, 0, 'h0102, 'h0002, 4);
        vecs[11] = mk(0, 'h0000, 'h0000, 1, 1, 1, 'h0103, 'h0003, 3);
        vecs[12] = mk(0, 'h0000, 'h0000, 1, 1, 1, 'h0104, 'h0004, 2);
        vecs[13] = mk(0, 'h0000, 'h0000, 1, 1, 1, 'h0105, 'h0005, 1);
        vecs[14] = mk(0, 'h0000, 'h0000, 0, 0, 1, 'h0000, 'h0000, 0);

        areset_n  = 1'b0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        mem_ready = 1'b0;
        #6;
        check("rst_count",     32'(count),     32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_wr_ready",  32'(wr_ready),  32'd1);
        check("rst_idle",      32'(idle),      32'd1);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_data",  32'(mem_data),  32'd0);
        areset_n = 1'b1;

`ifndef DATA_OUT_BUFFER_BYPASS_EN
        // Basic push/pop latency and full/hold-off behaviour.
        for (int i = 0; i < 15; i++) begin
            wr_valid  = vecs[i].wv;
            wr_addr   = vecs[i].a;
            wr_data   = vecs[i].d;
            mem_ready = vecs[i].mr;
            #2;
            check($sformatf("vec%0d_mem_valid", i), 32'(mem_valid), 32'(vecs[i].e_mv));
            check($sformatf("vec%0d_wr_ready", i),  32'(wr_ready),  32'(vecs[i].e_wr));
            check($sformatf("vec%0d_mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_ma));
            check($sformatf("vec%0d_mem_data", i),  32'(mem_data),  32'(vecs[i].e_md));
            check($sformatf("vec%0d_count", i),     32'(count),     32'(vecs[i].e_cnt));
            @(posedge clk);
            #1;
        end
`else
        // Same-cycle bypass into an empty buffer.
        wr_valid = 1'b1; wr_addr = 'h0020; wr_data = 'h0007; mem_ready = 1'b1;
        #2;
        check("byp_mem_valid", 32'(mem_valid), 32'd1);
        check("byp_mem_addr",  32'(mem_addr),  32'h0020);
        check("byp_mem_data",  32'(mem_data),  32'h0007);
        check("byp_count",     32'(count),     32'd0);
        @(posedge clk);
        #1;
        wr_valid = 1'b0; mem_ready = 1'b0;
        #1;
        check("byp_count_after", 32'(count),     32'd0);
        check("byp_valid_after", 32'(mem_valid), 32'd0);
        @(posedge clk);
        #1;
        // Bypass with memory stalled falls back to a normal push.
        cycle(1, 'h0030, 'h0009, 0, acc);
        cycle(0, '0, '0, 1, acc);
        cycle(0, '0, '0, 0, acc);
`endif
        q = {};

        // Half-full streaming across pointer wrap.
        cycle(1, 'h0200, 'h1000, 0, acc);
        cycle(1, 'h0201, 'h1001, 0, acc);
        for (int i = 0; i < 10; i++) begin
            cycle(1, W'(32'h0202 + i), W'(32'h1002 + i), 1, acc);
            check("stream_count", 32'(count), 32'd2);
        end
        cycle(0, '0, '0, 1, acc);
        cycle(0, '0, '0, 1, acc);
        cycle(0, '0, '0, 0, acc);

        // Held head stays stable while memory stalls randomly.
        cycle(1, 'h00FF, 'h00FF, 0, acc);
        popped = 1'b0;
        for (int i = 0; i < 50 && !popped; i++) begin
            mr = (i < 3) ? 1'b0 : 1'(($urandom_range(0, 3) == 0) || (i == 49));
            check("hold_mem_valid", 32'(mem_valid), 32'd1);
            check("hold_mem_addr",  32'(mem_addr),  32'h00FF);
            check("hold_mem_data",  32'(mem_data),  32'h00FF);
            cycle(0, '0, '0, mr, acc);
            popped = mr;
        end
        check("hold_accepted", 32'(popped), 32'd1);
        cycle(0, '0, '0, 0, acc);

        // Asynchronous reset mid-burst discards everything.
        cycle(1, 'h0301, 'h0011, 0, acc);
        cycle(1, 'h0302, 'h0022, 0, acc);
        cycle(1, 'h0303, 'h0033, 0, acc);
        check("burst_count", 32'(count), 32'd3);
        wr_valid = 1'b0;
        areset_n = 1'b0;
        #1;
        check("mid_rst_count",     32'(count),     32'd0);
        check("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
        check("mid_rst_idle",      32'(idle),      32'd1);
        check("mid_rst_wr_ready",  32'(wr_ready),  32'd1);
        check("mid_rst_mem_addr",  32'(mem_addr),  32'd0);
        check("mid_rst_mem_data",  32'(mem_data),  32'd0);
        #1;
        areset_n = 1'b1;
        q = {};
        cycle(1, 'h0400, 'h0044, 0, acc);
        check("first_push_count", 32'(count), 32'd1);
        cycle(0, '0, '0, 1, acc);
        for (int i = 0; i < 3; i++) cycle(0, '0, '0, 1, acc);

        // Randomized traffic; the CPU holds a request until it is accepted.
        pending = 1'b0;
        ra = '0;
        rd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pending) begin
                pending = ($urandom_range(0, 2) != 0);
                ra = W'($urandom);
                rd = W'($urandom);
            end
            mr = 1'($urandom_range(0, 1));
            cycle(pending, ra, rd, mr, acc);
            if (acc) pending = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
